// File: rtl/imm_decode_queue_if.sv
// rtl/imm_decode_queue_if.sv - instruction-in / immediate-out handshake bundle for imm_decode_queue
interface imm_decode_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_type;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_illegal, out_tag, count
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_illegal, out_tag, count
  );
endinterface

// File: rtl/imm_decode_queue.sv
// rtl/imm_decode_queue.sv - RISC-V immediate decoder feeding a DEPTH-entry tagged FIFO
// Optional feature macro: ZICSR_IMM_EN (csr*i instructions decode as zero-extended Z type)
module imm_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  imm_decode_queue_if.slave   bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
    T_U = 3'd4, T_J = 3'd5, T_Z = 3'd6, T_ILL = 3'd7
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_type_e        typ;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  imm_type_e       dec_type;
  logic            dec_illegal;
  logic [31:0]     imm32;
  logic [31:0]     ins;
  logic            push, pop;
  entry_t          head;

  assign ins = bus.in_instr;

  always_comb begin
    dec_type    = T_ILL;
    dec_illegal = 1'b0;
    case (ins[6:0])
      7'b0110011:                                     dec_type = T_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: dec_type = T_I;
      7'b0100011:                                     dec_type = T_S;
      7'b1100011:                                     dec_type = T_B;
      7'b0110111, 7'b0010111:                         dec_type = T_U;
      7'b1101111:                                     dec_type = T_J;
`ifdef ZICSR_IMM_EN
      7'b1110011:                                     dec_type = ins[14] ? T_Z : T_I;
`else
      7'b1110011:                                     dec_type = T_I;
`endif
      default: begin
        dec_type    = T_ILL;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Every form is built as 32 bits whose bit 31 is the sign; Z keeps bit 31 clear.
  always_comb begin
    imm32 = '0;
    case (dec_type)
      T_I:     imm32 = {{21{ins[31]}}, ins[30:20]};
      T_S:     imm32 = {{21{ins[31]}}, ins[30:25], ins[11:7]};
      T_B:     imm32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      T_U:     imm32 = {ins[31:12], 12'b0};
      T_J:     imm32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      T_Z:     imm32 = {27'b0, ins[19:15]};
      default: imm32 = '0;
    endcase
  end

  assign bus.in_ready = !flush && ((count_q < DEPTH_C) || bus.out_ready);
  assign push         = bus.in_valid && bus.in_ready && !flush;
  assign pop          = bus.out_valid && bus.out_ready && !flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q].imm     = XLEN'({{32{imm32[31]}}, imm32});
        mem_d[wr_ptr_q].typ     = dec_type;
        mem_d[wr_ptr_q].illegal = dec_illegal;
        mem_d[wr_ptr_q].tag     = bus.in_tag;
        wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign bus.out_valid   = (count_q != '0);
  assign bus.out_imm     = bus.out_valid ? head.imm : '0;
  assign bus.out_type    = bus.out_valid ? head.typ : 3'd0;
  assign bus.out_illegal = bus.out_valid ? head.illegal : 1'b0;
  assign bus.out_tag     = bus.out_valid ? head.tag : '0;
  assign bus.count       = count_q;
endmodule

// File: tb/tb_imm_decode_queue.sv
// tb/tb_imm_decode_queue.sv - table-driven scoreboard bench for imm_decode_queue (XLEN 32 and 64 instances)
module tb_imm_decode_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_tag = '0;
  logic        out_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  typ;
    logic        ill;
    logic [31:0] imm;
  } vec_t;

  typedef struct {
    logic [2:0]  typ;
    logic        ill;
    logic [31:0] imm;
    logic [31:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp;
  vec_t vecs[$];

  imm_decode_queue_if #(.XLEN(32), .DEPTH(2), .TAG_W(32)) bus32 ();
  imm_decode_queue_if #(.XLEN(64), .DEPTH(2), .TAG_W(32)) bus64 ();

  assign bus32.in_valid  = in_valid;
  assign bus32.in_instr  = in_instr;
  assign bus32.in_tag    = in_tag;
  assign bus32.out_ready = out_ready;
  assign bus64.in_valid  = in_valid;
  assign bus64.in_instr  = in_instr;
  assign bus64.in_tag    = in_tag;
  assign bus64.out_ready = out_ready;

  imm_decode_queue #(.XLEN(32), .DEPTH(2), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32.slave)
  );
  imm_decode_queue #(.XLEN(64), .DEPTH(2), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [2:0] typ, input logic ill,
                       input logic [31:0] imm, input logic [31:0] tag);
    in_valid    = 1'b1;
    in_instr    = instr;
    in_tag      = tag;
    cur_exp.typ = typ;
    cur_exp.ill = ill;
    cur_exp.imm = imm;
    cur_exp.tag = tag;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0 && !bus32.out_valid) break;
      step();
    end
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
    check("drain_out_valid", {63'd0, bus32.out_valid}, 64'd0);
  endtask

  // Scoreboard monitor: pops are checked before the same-cycle push is recorded.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (!flush && bus32.out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got tag %h, expected no entry", bus32.out_tag);
        end else begin
          e = sb.pop_front();
          check("type32", {61'd0, bus32.out_type}, {61'd0, e.typ});
          check("illegal32", {63'd0, bus32.out_illegal}, {63'd0, e.ill});
          check("imm32", {32'd0, bus32.out_imm}, {32'd0, e.imm});
          check("tag32", {32'd0, bus32.out_tag}, {32'd0, e.tag});
          check("imm64", bus64.out_imm, {{32{e.imm[31]}}, e.imm});
          check("type64", {61'd0, bus64.out_type}, {61'd0, e.typ});
        end
      end
      if (flush) sb.delete();
      else if (in_valid && bus32.in_ready) sb.push_back(cur_exp);
    end
  end

  initial begin
    vecs.push_back('{32'hFFF00093, 3'd1, 1'b0, 32'hFFFFFFFF});
    vecs.push_back('{32'hFE112E23, 3'd2, 1'b0, 32'hFFFFFFFC});
    vecs.push_back('{32'hFF9FF06F, 3'd5, 1'b0, 32'hFFFFFFF8});
    vecs.push_back('{32'h123452B7, 3'd4, 1'b0, 32'h12345000});
    vecs.push_back('{32'h800002B7, 3'd4, 1'b0, 32'h80000000});
    vecs.push_back('{32'h0000007F, 3'd7, 1'b1, 32'h00000000});
    vecs.push_back('{32'h00B50533, 3'd0, 1'b0, 32'h00000000});
    vecs.push_back('{32'hFE000EE3, 3'd3, 1'b0, 32'hFFFFFFFC});
    vecs.push_back('{32'hFFFFF097, 3'd4, 1'b0, 32'hFFFFF000});
    vecs.push_back('{32'h80012083, 3'd1, 1'b0, 32'hFFFFF800});
    vecs.push_back('{32'h0000000F, 3'd1, 1'b0, 32'h00000000});
    vecs.push_back('{32'hF0000067, 3'd1, 1'b0, 32'hFFFFFF00});
    vecs.push_back('{32'h00000073, 3'd1, 1'b0, 32'h00000000});
`ifdef ZICSR_IMM_EN
    vecs.push_back('{32'h3002D073, 3'd6, 1'b0, 32'h00000005});
`else
    vecs.push_back('{32'h3002D073, 3'd1, 1'b0, 32'h00000300});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {63'd0, bus32.out_valid}, 64'd0);
    check("reset_count", {62'd0, bus32.count}, 64'd0);
    check("reset_out_imm", {32'd0, bus32.out_imm}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", {63'd0, bus32.in_ready}, 64'd1);
    step();

    // Streaming at full throughput through both widths
    out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].instr, vecs[i].typ, vecs[i].ill, vecs[i].imm, 32'(100 + i));
      step();
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: fill, push+pop while full, drain order
    out_ready = 1'b0;
    drive(32'hFFF00093, 3'd1, 1'b0, 32'hFFFFFFFF, 32'd1);
    step();
    check("latency_out_valid", {63'd0, bus32.out_valid}, 64'd1);
    check("latency_out_type", {61'd0, bus32.out_type}, 64'd1);
    check("latency_out_imm", {32'd0, bus32.out_imm}, 64'hFFFFFFFF);
    drive(32'hFE112E23, 3'd2, 1'b0, 32'hFFFFFFFC, 32'd2);
    step();
    check("full_in_ready", {63'd0, bus32.in_ready}, 64'd0);
    check("full_count", {62'd0, bus32.count}, 64'd2);
    drive(32'hFF9FF06F, 3'd5, 1'b0, 32'hFFFFFFF8, 32'd3);
    step();
    check("full_hold_count", {62'd0, bus32.count}, 64'd2);
    out_ready = 1'b1;
    #1;
    check("full_ready_passthru", {63'd0, bus32.in_ready}, 64'd1);
    step();
    check("pushpop_count", {62'd0, bus32.count}, 64'd2);
    check("pushpop_head_tag", {32'd0, bus32.out_tag}, 64'd2);
    in_valid = 1'b0;
    drain();

    // Flush with a concurrent push
    out_ready = 1'b0;
    drive(32'h123452B7, 3'd4, 1'b0, 32'h12345000, 32'd11);
    step();
    drive(32'h0000007F, 3'd7, 1'b1, 32'h00000000, 32'd12);
    step();
    check("preflush_count", {62'd0, bus32.count}, 64'd2);
    drive(32'hFFF00093, 3'd1, 1'b0, 32'hFFFFFFFF, 32'd99);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count", {62'd0, bus32.count}, 64'd0);
    check("flush_out_valid", {63'd0, bus32.out_valid}, 64'd0);
    check("flush_out_imm", {32'd0, bus32.out_imm}, 64'd0);
    check("flush_out_type", {61'd0, bus32.out_type}, 64'd0);
    check("flush_out_tag", {32'd0, bus32.out_tag}, 64'd0);
    out_ready = 1'b1;
    repeat (3) step();
    check("flush_no_ghost", {63'd0, bus32.out_valid}, 64'd0);

    // Illegal head visible, then asynchronous reset mid-queue
    out_ready = 1'b0;
    drive(32'h0000007F, 3'd7, 1'b1, 32'h00000000, 32'd21);
    step();
    check("illegal_flag", {63'd0, bus32.out_illegal}, 64'd1);
    check("illegal_type", {61'd0, bus32.out_type}, 64'd7);
    check("illegal_imm", {32'd0, bus32.out_imm}, 64'd0);
    drive(32'hFFF00093, 3'd1, 1'b0, 32'hFFFFFFFF, 32'd22);
    step();
    in_valid = 1'b0;
    check("prereset_count", {62'd0, bus32.count}, 64'd2);
    rst_n = 1'b0;
    #2;
    check("async_reset_out_valid", {63'd0, bus32.out_valid}, 64'd0);
    check("async_reset_count", {62'd0, bus32.count}, 64'd0);
    check("async_reset_count64", {62'd0, bus64.count}, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) step();
    check("post_reset_empty", {63'd0, bus32.out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
